// File: rtl/ccff_pkg.sv
// Shared state encoding and default sizing for the configuration-chain loader.
package ccff_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } ccff_state_e;

  localparam int CCFF_WORD_W_DEF    = 32;
  localparam int CCFF_CHAIN_LEN_DEF = 4096;

endpackage

// File: rtl/ccff_serializer.sv
// Word-to-bit serializer: loads a word masked to the bits the pass still needs, shifts it out LSB first.
// Load has priority over shift; last_bit flags the final bit of the loaded word (no internal backpressure).
module ccff_serializer
  import ccff_pkg::*;
#(
  parameter int WORD_W = CCFF_WORD_W_DEF,
  parameter int CNT_W  = $clog2(CCFF_CHAIN_LEN_DEF + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic [CNT_W-1:0]  bits_rem,
  input  logic              shift,
  output logic              head_bit,
  output logic              last_bit
);

  localparam int LEFT_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [LEFT_W-1:0] word_left_q, word_left_d;
  logic [LEFT_W-1:0] load_left;

  always_comb begin
    load_left   = (int'(bits_rem) < WORD_W) ? LEFT_W'(bits_rem) : LEFT_W'(WORD_W);
    shreg_d     = shreg_q;
    word_left_d = word_left_q;
    if (load) begin
      // Bits beyond the end of the chain are zeroed so the head idles low afterwards.
      for (int i = 0; i < WORD_W; i++) begin
        shreg_d[i] = load_data[i] & (i < int'(load_left));
      end
      word_left_d = load_left;
    end else if (shift) begin
      shreg_d     = shreg_q >> 1;
      word_left_d = word_left_q - LEFT_W'(1);
    end
  end

  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      shreg_q     <= '0;
      word_left_q <= '0;
    end else begin
      shreg_q     <= shreg_d;
      word_left_q <= word_left_d;
    end
  end

  assign head_bit = shreg_q[0];
  assign last_bit = (word_left_q == LEFT_W'(1));

endmodule

// File: rtl/ccff_loader.sv
// Serializes bitstream words onto a config chain, with optional readback pass; first bit 2 cycles after start, then 1 bit/cycle.
// word_ready only in FETCH or on a word's last bit with more to send; an absent word parks the FSM in FETCH.
module ccff_loader
  import ccff_pkg::*;
#(
  parameter int WORD_W    = CCFF_WORD_W_DEF,
  parameter int CHAIN_LEN = CCFF_CHAIN_LEN_DEF,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              verify,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              shift_en,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  bit_cnt
);

  ccff_state_e      state_q, state_d;
  logic             pass_q, pass_d;
  logic             verify_q, verify_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             shift_en_q, shift_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             load;
  logic             last_bit;
  logic             pass_end;
  logic [CNT_W-1:0] bits_rem;

  assign pass_end = (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));

  always_comb begin
    state_d    = state_q;
    pass_d     = pass_q;
    verify_d   = verify_q;
    error_d    = error_q;
    bit_cnt_d  = bit_cnt_q;
    word_ready = 1'b0;
    load       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          verify_d  = verify;
          error_d   = 1'b0;
          bit_cnt_d = '0;
          pass_d    = 1'b0;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        word_ready = 1'b1;
        if (word_valid) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        // The oldest chain bit is the same-index bit of the first pass.
        if (pass_q && (ccff_tail != ccff_head)) begin
          error_d = 1'b1;
        end
        if (pass_end) begin
          if (verify_q && !pass_q) begin
            pass_d    = 1'b1;
            bit_cnt_d = '0;
            state_d   = FETCH;
          end else begin
            state_d = DONE;
          end
        end else if (last_bit) begin
          word_ready = 1'b1;
          if (word_valid) begin
            load = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    bits_rem   = CNT_W'(CHAIN_LEN) - bit_cnt_d;
    shift_en_d = (state_d == SHIFT);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      state_q    <= IDLE;
      pass_q     <= 1'b0;
      verify_q   <= 1'b0;
      error_q    <= 1'b0;
      bit_cnt_q  <= '0;
      shift_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pass_q     <= pass_d;
      verify_q   <= verify_d;
      error_q    <= error_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_en_q <= shift_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  ccff_serializer #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_ser (
    .prog_clk  (prog_clk),
    .pReset    (pReset),
    .load      (load),
    .load_data (word_data),
    .bits_rem  (bits_rem),
    .shift     (shift_en_q),
    .head_bit  (ccff_head),
    .last_bit  (last_bit)
  );

  assign shift_en = shift_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign bit_cnt  = bit_cnt_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader (WORD_W=4, CHAIN_LEN=10) with a behavioural chain model and a bit/done scoreboard.
module tb_ccff_loader;

  localparam int WORD_W    = 4;
  localparam int CHAIN_LEN = 10;
  localparam int CNT_W     = 4;

  logic              prog_clk = 1'b0;
  logic              pReset, start, verify, word_valid, word_ready;
  logic [WORD_W-1:0] word_data;
  logic              ccff_head, ccff_tail, shift_en, busy, done, error;
  logic [CNT_W-1:0]  bit_cnt;

  typedef struct { logic b; int cnt; } exp_bit_t;
  typedef struct { int cyc; int err; int shifts; int gaps; } exp_done_t;

  exp_bit_t  exp_bits[$];
  exp_done_t exp_done[$];

  int checks = 0;
  int failures = 0;
  int ld_cyc = 0, n_shift = 0, n_gap = 0;

  logic [CHAIN_LEN-1:0] chain = '0;
  logic                 fault_en = 1'b0;
  int                   sh_idx = 0;
  logic [9:0]           exp_seq;
  logic [9:0]           exp_chain;
  logic [3:0]           words [3];

  always #5 prog_clk = ~prog_clk;

  ccff_loader #(
    .WORD_W    (WORD_W),
    .CHAIN_LEN (CHAIN_LEN)
  ) dut (
    .prog_clk   (prog_clk),
    .pReset     (pReset),
    .start      (start),
    .verify     (verify),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_ready (word_ready),
    .ccff_head  (ccff_head),
    .ccff_tail  (ccff_tail),
    .shift_en   (shift_en),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .bit_cnt    (bit_cnt)
  );

  // Chain model; fault_en corrupts the 8th bit shifted in during a load.
  always @(posedge prog_clk) begin
    if (busy !== 1'b1) begin
      sh_idx <= 0;
    end else if (shift_en === 1'b1) begin
      chain  <= {chain[CHAIN_LEN-2:0], ccff_head ^ (fault_en && sh_idx == 7)};
      sh_idx <= sh_idx + 1;
    end
  end
  assign ccff_tail = chain[CHAIN_LEN-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge prog_clk) begin
    exp_bit_t  eb;
    exp_done_t ed;
    if (busy !== 1'b1) begin
      ld_cyc = 0; n_shift = 0; n_gap = 0;
    end else begin
      ld_cyc++;
      if (shift_en === 1'b1) n_shift++;
      else n_gap++;
    end
    if (shift_en === 1'b1) begin
      if (exp_bits.size() == 0) begin
        checks++; failures++;
        $display("FAIL extra_shift: got shift_en=1 expected no shift");
      end else begin
        eb = exp_bits.pop_front();
        check("head_bit", ccff_head, eb.b);
        check("shift_bitcnt", bit_cnt, eb.cnt);
      end
    end
    if (done === 1'b1) begin
      if (exp_done.size() == 0) begin
        checks++; failures++;
        $display("FAIL extra_done: got done=1 expected none");
      end else begin
        ed = exp_done.pop_front();
        check("done_cycle", ld_cyc, ed.cyc);
        check("done_error", error, ed.err);
        check("done_bitcnt", bit_cnt, CHAIN_LEN);
        check("done_shifts", n_shift, ed.shifts);
        check("done_gaps", n_gap, ed.gaps);
      end
    end
  end

  task automatic drive_word(input logic [3:0] d);
    int t = 0;
    word_valid = 1'b1;
    word_data  = d;
    while (word_ready !== 1'b1 && t < 100) begin
      @(negedge prog_clk);
      t++;
    end
    check("word_accept", word_ready, 1);
    @(negedge prog_clk);
    word_valid = 1'b0;
  endtask

  task automatic run_load(input logic v, input logic [3:0] w2, input int stall_n,
                          input int exp_err, input int exp_cyc, input int exp_gaps,
                          input logic mid_start);
    exp_done_t e;
    int npass = v ? 2 : 1;
    int t;
    for (int p = 0; p < npass; p++)
      for (int i = 0; i < CHAIN_LEN; i++) exp_bits.push_back('{exp_seq[i], i});
    e = '{exp_cyc, exp_err, CHAIN_LEN * npass, exp_gaps};
    exp_done.push_back(e);
    start  = 1'b1;
    verify = v;
    @(negedge prog_clk);
    start  = 1'b0;
    verify = 1'b0;
    check("start_err_clr", error, 0);
    check("start_busy", busy, 1);
    check("fetch_ready", word_ready, 1);
    for (int p = 0; p < npass; p++) begin
      for (int i = 0; i < 3; i++) begin
        if (p == 0 && i == 1 && stall_n > 0) begin
          word_valid = 1'b0;
          t = 0;
          while (word_ready !== 1'b1 && t < 100) begin
            @(negedge prog_clk);
            t++;
          end
          repeat (stall_n) @(negedge prog_clk);
        end
        drive_word(i == 2 ? w2 : words[i]);
        if (mid_start && p == 0 && i == 0) begin
          start  = 1'b1;
          verify = 1'b1;
          @(negedge prog_clk);
          start  = 1'b0;
          verify = 1'b0;
        end
      end
    end
    t = 0;
    while (done !== 1'b1 && t < 100) begin
      @(negedge prog_clk);
      t++;
    end
    check("done_seen", done, 1);
    @(negedge prog_clk);
    check("err_hold", error, exp_err);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    exp_seq   = 10'b1110100101;
    exp_chain = 10'b1010010111;
    words[0] = 4'h5; words[1] = 4'hA; words[2] = 4'h3;
    pReset = 1'b0; start = 1'b0; verify = 1'b0;
    word_valid = 1'b0; word_data = '0;
    repeat (3) @(negedge prog_clk);
    check("rst_ready", word_ready, 0);
    check("rst_head", ccff_head, 0);
    check("rst_shift", shift_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_bitcnt", bit_cnt, 0);
    pReset = 1'b1;
    @(negedge prog_clk);

    run_load(1'b0, 4'h3, 0, 0, 12, 2, 1'b0);
    check("chain_basic", chain, exp_chain);
    run_load(1'b0, 4'hF, 0, 0, 12, 2, 1'b0);
    check("chain_discard", chain, exp_chain);
    run_load(1'b1, 4'h3, 0, 0, 23, 3, 1'b0);
    fault_en = 1'b1;
    run_load(1'b1, 4'h3, 0, 1, 23, 3, 1'b0);
    fault_en = 1'b0;
    run_load(1'b0, 4'h3, 5, 0, 17, 7, 1'b0);
    check("chain_stall", chain, exp_chain);

    for (int i = 0; i < 5; i++) exp_bits.push_back('{exp_seq[i], i});
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    drive_word(words[0]);
    drive_word(words[1]);
    pReset = 1'b0;
    @(negedge prog_clk);
    check("mr_ready", word_ready, 0);
    check("mr_head", ccff_head, 0);
    check("mr_shift", shift_en, 0);
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    check("mr_error", error, 0);
    check("mr_bitcnt", bit_cnt, 0);
    pReset = 1'b1;
    @(negedge prog_clk);
    run_load(1'b0, 4'h3, 0, 0, 12, 2, 1'b0);
    check("chain_after_rst", chain, exp_chain);

    run_load(1'b0, 4'h3, 0, 0, 12, 2, 1'b1);
    repeat (5) @(negedge prog_clk);
    check("bits_left", exp_bits.size(), 0);
    check("dones_left", exp_done.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
